// File: rtl/serial_port_arbiter.sv
// -----------------------------------------------------------------------------
// serial_port_arbiter
//
// Round-robin arbiter and sequencer that shares one SerialCTL shift-register
// port among NREQ requesters. A winner is chosen in IDLE, its word is latched
// onto Data together with a one-cycle Start pulse, and the block then waits
// for a rising edge of DoneFlag. It acknowledges the owner and enforces a
// minimum idle gap before arbitrating again.
//
// Optional feature: define SERIAL_ARB_TIMEOUT_EN to build a WAIT-state
// timeout. The transfer is aborted after TIMEOUT cycles, and Ack and Error
// pulse together. Without the macro WAIT is unbounded and Error is tied low.
//
// Parameters:
//   NREQ     number of requesters (2..8)
//   DWIDTH   word width, matches the SerialCTL Data width
//   GAP      idle cycles forced after ACK (0..15)
//   TIMEOUT  WAIT cycles before abort (timeout build only)
//
// Ports:
//   Clock     in   system clock, rising edge
//   Reset     in   asynchronous active-high reset
//   Req       in   per-requester request level
//   ReqData   in   per-requester word, requester i at [i*DWIDTH +: DWIDTH]
//   Grant     out  one-hot owner of the port, zero when idle
//   Ack       out  one-cycle completion pulse to the owner
//   Busy      out  high whenever the sequencer is not IDLE
//   Start     out  one-cycle pulse to SerialCTL Start
//   Data      out  registered word to SerialCTL Data
//   DoneFlag  in   SerialCTL completion flag
//   Error     out  one-cycle timeout pulse coincident with Ack
// -----------------------------------------------------------------------------
module serial_port_arbiter #(
    parameter int NREQ    = 4,
    parameter int DWIDTH  = 32,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NREQ-1:0]          Req,
    input  logic [NREQ*DWIDTH-1:0]   ReqData,
    output logic [NREQ-1:0]          Grant,
    output logic [NREQ-1:0]          Ack,
    output logic                     Busy,
    output logic                     Start,
    output logic [DWIDTH-1:0]        Data,
    input  logic                     DoneFlag,
    output logic                     Error
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_ACK,
        S_GAP
    } state_t;

    state_t             state_reg, state_next;
    logic [IW-1:0]      ptr_reg, ptr_next;
    logic [NREQ-1:0]    grant_reg, grant_next;
    logic [DWIDTH-1:0]  data_reg, data_next;
    logic [3:0]         gap_cnt_reg, gap_cnt_next;
    logic               done_q_reg;

    logic [DWIDTH-1:0]  req_words [NREQ];
    logic [NREQ-1:0]    arb_onehot;
    logic [IW-1:0]      arb_idx;
    logic [IW-1:0]      cand_idx;
    logic               arb_found;
    logic               done_rise;
    logic               to_hit;

    // Unpack the flat request bus and decode the arbitration winner one-hot.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign req_words[gi]  = ReqData[gi*DWIDTH +: DWIDTH];
        assign arb_onehot[gi] = (arb_idx == IW'(gi));
    end

    // Round-robin scan starting one past the last winner, wrapping modulo NREQ.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = ptr_reg;
        cand_idx  = ptr_reg;
        for (int off = 1; off <= NREQ; off++) begin
            cand_idx = IW'((int'(ptr_reg) + off) % NREQ);
            if (!arb_found && Req[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    // Only a fresh 0->1 edge counts; a level left high by the previous
    // transfer has already been absorbed by done_q_reg.
    assign done_rise = DoneFlag & ~done_q_reg;

`ifdef SERIAL_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt_reg;
    logic          err_reg;

    assign to_hit = (to_cnt_reg == TW'(TIMEOUT - 1));

    // Counter is zeroed while in START so it reads 0 on the first WAIT cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            to_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (state_reg == S_START) begin
                to_cnt_reg <= '0;
            end else if (state_reg == S_WAIT) begin
                to_cnt_reg <= to_cnt_reg + 1'b1;
            end
            // Aligns with the ACK cycle entered by the timeout.
            err_reg <= (state_reg == S_WAIT) && !done_rise && to_hit;
        end
    end

    assign Error = err_reg;
`else
    assign to_hit = 1'b0;
    assign Error  = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg   <= S_IDLE;
            ptr_reg     <= IW'(NREQ - 1);
            grant_reg   <= '0;
            data_reg    <= '0;
            gap_cnt_reg <= '0;
            done_q_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            grant_reg   <= grant_next;
            data_reg    <= data_next;
            gap_cnt_reg <= gap_cnt_next;
            done_q_reg  <= DoneFlag;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ptr_next     = ptr_reg;
        grant_next   = grant_reg;
        data_next    = data_reg;
        gap_cnt_next = gap_cnt_reg;

        case (state_reg)
            S_IDLE: begin
                if (arb_found) begin
                    state_next = S_START;
                    ptr_next   = arb_idx;
                    grant_next = arb_onehot;
                    data_next  = req_words[arb_idx];
                end
            end
            S_START: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (done_rise || to_hit) begin
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                grant_next   = '0;
                data_next    = '0;
                gap_cnt_next = '0;
                state_next   = (GAP > 0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = S_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                grant_next = '0;
                data_next  = '0;
            end
        endcase
    end

    // Outputs decode directly from registers so the async reset clears them
    // without waiting for a clock edge.
    assign Grant = grant_reg;
    assign Data  = data_reg;
    assign Start = (state_reg == S_START);
    assign Busy  = (state_reg != S_IDLE);
    assign Ack   = (state_reg == S_ACK) ? grant_reg : '0;

endmodule

// File: doc/serial_port_arbiter.md
# serial_port_arbiter

Round-robin arbiter and sequencer that shares one SerialCTL shift-register port among `NREQ` requesters. It selects a requester, presents its 32-bit word on `Data` with a single-cycle `Start` pulse, and waits for SerialCTL's `DoneFlag`. It then acknowledges the requester and enforces a minimum idle gap before the next transfer. It sits between the counter/control logic that produces words and the SerialCTL instance that drives SS/SCLK/MOSI.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `DWIDTH`, 32: word width; must match the SerialCTL `Data` width.
- `GAP`, 2: idle cycles forced between the end of one transfer and the next arbitration (0..15).
- `TIMEOUT`, 1024: cycles allowed in WAIT before abort. Used only with the `SERIAL_ARB_TIMEOUT_EN` macro.

- `Clock`  in  1  system clock, rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `Req`  in  NREQ  per-requester request level.
- `ReqData`  in  NREQ*DWIDTH  per-requester word; requester i occupies bits [i*DWIDTH +: DWIDTH].
- `Grant`  out  NREQ  one-hot owner of the port; zero when idle.
- `Ack`  out  NREQ  one-cycle completion pulse to the owner.
- `Busy`  out  1  high whenever state is not IDLE.
- `Start`  out  1  one-cycle pulse to SerialCTL `Start`.
- `Data`  out  DWIDTH  registered word to SerialCTL `Data`.
- `DoneFlag`  in  1  SerialCTL completion flag.
- `Error`  out  1  one-cycle timeout pulse coincident with `Ack`.

## Operation
- States and transitions:
  - IDLE → START when any `Req` bit is high.
  - START → WAIT after one cycle.
  - WAIT → ACK on completion, or on timeout.
  - ACK → GAP when `GAP` > 0; ACK → IDLE when `GAP` = 0.
  - GAP → IDLE after `GAP` cycles.
- Reset state: all outputs 0, state IDLE, priority pointer = NREQ-1, so requester 0 has highest priority first.
- Arbitration happens in IDLE:
  - Scan starts at index pointer+1 and wraps modulo NREQ; the first set `Req` bit wins.
  - On the IDLE→START edge: the winner index is latched, `Grant` is set one-hot, `Data` is loaded from `ReqData[winner]`, and the pointer is set to the winner.
- `Grant` and `Data` are held constant from START through ACK. Both clear on entry to GAP or IDLE.
- Completion is a rising edge of `DoneFlag`:
  - `DoneFlag` is registered every cycle.
  - Completion means `DoneFlag`=1 and the registered value is 0, evaluated only in WAIT.
  - A level left high from a previous transfer is never counted.
- A requester must hold `Req` and `ReqData` until its `Ack`. Dropping `Req` after grant does not abort: the transfer completes and `Ack` is still issued.
- `Req` changes during START, WAIT, ACK and GAP are ignored until the next IDLE.
- Asserting `Reset` mid-transfer returns to reset state immediately. `Start`, `Grant` and `Ack` drop without waiting for the clock. SerialCTL is reset from the same `Reset` net.

## Timing
- A request seen in IDLE at edge T gives `Start`=1, valid `Grant` and valid `Data` during cycle T+1. WAIT begins at T+2.
- A `DoneFlag` rise sampled at edge D (in WAIT) gives `Ack`=1 during cycle D+1.
- Next arbitration happens no earlier than D+2+GAP.
- Back-to-back throughput: transfer time + 3 + GAP cycles per word.
- At most one `Start` is issued per `Ack`. `Start` never occurs outside the START state.

## Configuration
- `SERIAL_ARB_TIMEOUT_EN` defined:
  - A counter clears on WAIT entry and increments every WAIT cycle.
  - Reaching `TIMEOUT` without completion forces ACK, with `Ack[winner]`=1 and `Error`=1 in the same cycle.
  - The pointer still advances.
- `SERIAL_ARB_TIMEOUT_EN` undefined:
  - No counter is built and WAIT is unbounded.
  - `Error` is tied to 0.

## Test plan
1. Reset, then Req=4'b0001 with ReqData[0]=32'h6bc57a91 → one `Start` pulse one cycle later, `Data`=32'h6bc57a91, `Grant`=4'b0001. A `DoneFlag` rise gives `Ack`=4'b0001 on the next cycle, then GAP=2 idle cycles.
2. Req=4'b1111 held, each `Req` bit dropped after its `Ack` → grants in order 0,1,2,3, exactly 4 `Start` pulses, every word matches its ReqData.
3. After a grant to 1, Req=4'b0011 → next grant goes to 0 (priority order 2,3,0,1). A later Req=4'b0011 → grant goes to 1.
4. `DoneFlag` held high across ACK/GAP into the next WAIT → no premature `Ack`. The next `Ack` follows only a fresh 0→1 transition.
5. Assert `Reset` during WAIT → `Grant`, `Start`, `Ack` and `Busy` drop without a clock edge. After release, Req=4'b0100 → granted to 2 with the pointer starting from reset.
6. With `SERIAL_ARB_TIMEOUT_EN` and TIMEOUT=16, `DoneFlag` held at 0 → `Ack` and `Error` pulse together 16 cycles after WAIT entry. Without the macro, `Busy` stays high and `Error` stays 0.
